inst_seq: RTL and testbench

INST_SEQ -- requirements
Module: inst_seq

---
 rtl/inst_seq_pkg.sv | 63 ++++++
 rtl/inst_seq_inst_pack.sv | 41 ++++
 rtl/inst_seq.sv | 232 +++++++++++++++++++++++
 tb/tb_inst_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_seq_pkg.sv
// Shared definitions for the inst_seq instruction sequencer: instruction bit map,
// idle word, FSM states and address constants. ACC_PHASE_EN adds the accumulate state.
package inst_seq_pkg;

  localparam int INST_W = 34;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 7;
  localparam int KIJ_W  = 4;
  localparam int ONIJ_W = 5;

  // Bit positions of the core instruction word
  localparam int INST_ACC      = 33;
  localparam int INST_CEN_PMEM = 32;
  localparam int INST_WEN_PMEM = 31;
  localparam int INST_A_PMEM   = 20;
  localparam int INST_CEN_XMEM = 19;
  localparam int INST_WEN_XMEM = 18;
  localparam int INST_A_XMEM   = 7;
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_L0_RD    = 3;
  localparam int INST_L0_WR    = 2;
  localparam int INST_EXECUTE  = 1;
  localparam int INST_LOAD     = 0;

  localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;
  localparam logic [ADDR_W-1:0] W_BASE    = 11'd1024;
  localparam int                GAP_CYCLES = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_L0,
    S_LOAD,
    S_GAP,
    S_A_L0,
    S_EXEC,
    S_DRAIN,
    S_NEXT
`ifdef ACC_PHASE_EN
    ,
    S_ACC
`endif
  } state_e;

  typedef struct packed {
    logic              acc;
    logic              cen_pmem;
    logic              wen_pmem;
    logic [ADDR_W-1:0] a_pmem;
    logic              cen_xmem;
    logic              wen_xmem;
    logic [ADDR_W-1:0] a_xmem;
    logic              ofifo_rd;
    logic              ififo_wr;
    logic              ififo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_fields_t;

endpackage

// File: rtl/inst_seq_inst_pack.sv
// Combinational packer placing named instruction fields at the bit positions
// the core decodes.
module inst_pack
  import inst_seq_pkg::*;
(
  input  logic              acc,
  input  logic              cen_pmem,
  input  logic              wen_pmem,
  input  logic [ADDR_W-1:0] a_pmem,
  input  logic              cen_xmem,
  input  logic              wen_xmem,
  input  logic [ADDR_W-1:0] a_xmem,
  input  logic              ofifo_rd,
  input  logic              ififo_wr,
  input  logic              ififo_rd,
  input  logic              l0_rd,
  input  logic              l0_wr,
  input  logic              execute,
  input  logic              load,
  output logic [INST_W-1:0] inst
);

  always_comb begin
    inst                         = '0;
    inst[INST_ACC]               = acc;
    inst[INST_CEN_PMEM]          = cen_pmem;
    inst[INST_WEN_PMEM]          = wen_pmem;
    inst[INST_A_PMEM +: ADDR_W]  = a_pmem;
    inst[INST_CEN_XMEM]          = cen_xmem;
    inst[INST_WEN_XMEM]          = wen_xmem;
    inst[INST_A_XMEM +: ADDR_W]  = a_xmem;
    inst[INST_OFIFO_RD]          = ofifo_rd;
    inst[INST_IFIFO_WR]          = ififo_wr;
    inst[INST_IFIFO_RD]          = ififo_rd;
    inst[INST_L0_RD]             = l0_rd;
    inst[INST_L0_WR]             = l0_wr;
    inst[INST_EXECUTE]           = execute;
    inst[INST_LOAD]              = load;
  end

endmodule

// File: rtl/inst_seq.sv
// Instruction sequencer driving one convolution run across all kernel positions.
// Define ACC_PHASE_EN to append the pmem accumulate read-back phase.
module inst_seq
  import inst_seq_pkg::*;
#(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int len_nij  = 36,
  parameter int len_onij = 16,
  parameter int len_kij  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0]  W_END    = CNT_W'(col);
  localparam logic [CNT_W-1:0]  LD_END   = CNT_W'(row);
  localparam logic [CNT_W-1:0]  GAP_END  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  NIJ_END  = CNT_W'(len_nij);
  localparam logic [KIJ_W-1:0]  KIJ_LAST = KIJ_W'(len_kij - 1);
  localparam logic [ONIJ_W-1:0] ONIJ_CNT = ONIJ_W'(len_onij);
  localparam logic [ADDR_W-1:0] ONIJ_A   = ADDR_W'(len_onij);
`ifdef ACC_PHASE_EN
  localparam logic [CNT_W-1:0]  KCNT      = CNT_W'(len_kij);
  localparam logic [CNT_W-1:0]  ACC_END   = CNT_W'(len_kij + 1);
  localparam logic [ONIJ_W-1:0] ONIJ_LAST = ONIJ_W'(len_onij - 1);
`endif

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [KIJ_W-1:0]    kij_q, kij_d;
  logic [ONIJ_W-1:0]   onij_q, onij_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                rd_nxt;
  logic                wr_nxt;
  logic [ADDR_W-1:0]   wr_addr;
  logic                cur_rd;
  inst_fields_t        f;

  // The read issued in the current cycle is written to pmem in the next one.
  assign cur_rd = inst_q[INST_OFIFO_RD];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    kij_d   = kij_q;
    onij_d  = onij_q;
    rd_nxt  = 1'b0;
    wr_nxt  = 1'b0;
    wr_addr = ADDR_W'(kij_q) * ONIJ_A + ADDR_W'(onij_q) - ADDR_W'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_W_L0;
          kij_d   = '0;
          onij_d  = '0;
        end
      end
      S_W_L0: if (cnt_q == W_END) begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
      S_LOAD: if (cnt_q == LD_END) begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: if (cnt_q == GAP_END) begin
        state_d = S_A_L0;
        cnt_d   = '0;
      end
      S_A_L0: if (cnt_q == NIJ_END) begin
        state_d = S_EXEC;
        cnt_d   = '0;
      end
      S_EXEC: if (cnt_q == NIJ_END) begin
        state_d = S_DRAIN;
        cnt_d   = '0;
        rd_nxt  = ofifo_valid;
        onij_d  = ONIJ_W'(ofifo_valid);
      end
      S_DRAIN: begin
        cnt_d  = cnt_q;
        wr_nxt = cur_rd;
        // Leave only once every read has been issued and its write retired.
        if (onij_q == ONIJ_CNT && !cur_rd) begin
          state_d = S_NEXT;
          cnt_d   = '0;
        end else begin
          rd_nxt = ofifo_valid && (onij_q != ONIJ_CNT);
          onij_d = onij_q + ONIJ_W'(rd_nxt);
        end
      end
      S_NEXT: begin
        cnt_d = '0;
        if (kij_q != KIJ_LAST) begin
          kij_d   = kij_q + KIJ_W'(1);
          state_d = S_W_L0;
        end else begin
`ifdef ACC_PHASE_EN
          state_d = S_ACC;
          onij_d  = '0;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef ACC_PHASE_EN
      S_ACC: if (cnt_q == ACC_END) begin
        cnt_d = '0;
        if (onij_q == ONIJ_LAST) begin
          state_d = S_IDLE;
          onij_d  = '0;
        end else begin
          onij_d = onij_q + ONIJ_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output fields describe the cycle about to be entered, so they register cleanly.
  always_comb begin
    f          = '0;
    f.cen_pmem = 1'b1;
    f.wen_pmem = 1'b1;
    f.cen_xmem = 1'b1;
    f.wen_xmem = 1'b1;
    busy_d     = (state_d != S_IDLE);
    done_d     = 1'b0;
    case (state_d)
      S_W_L0: begin
        if (cnt_d < W_END) begin
          f.cen_xmem = 1'b0;
          f.a_xmem   = W_BASE + ADDR_W'(cnt_d);
        end
        f.l0_wr = (cnt_d != '0);
      end
      S_LOAD: begin
        f.load  = 1'b1;
        f.l0_rd = 1'b1;
      end
      S_A_L0: begin
        if (cnt_d < NIJ_END) begin
          f.cen_xmem = 1'b0;
          f.a_xmem   = ADDR_W'(cnt_d);
        end
        f.l0_wr = (cnt_d != '0);
      end
      S_EXEC: begin
        f.execute  = 1'b1;
        f.ififo_rd = 1'b1;
      end
      S_DRAIN: begin
        f.ofifo_rd = rd_nxt;
        if (wr_nxt) begin
          f.cen_pmem = 1'b0;
          f.wen_pmem = 1'b0;
          f.a_pmem   = wr_addr;
        end
      end
      S_NEXT: begin
`ifndef ACC_PHASE_EN
        done_d = (kij_d == KIJ_LAST);
`endif
      end
`ifdef ACC_PHASE_EN
      S_ACC: begin
        if (cnt_d < KCNT) begin
          f.cen_pmem = 1'b0;
          f.a_pmem   = ADDR_W'(cnt_d) * ONIJ_A + ADDR_W'(onij_d);
        end
        f.acc  = (cnt_d != '0) && (cnt_d <= KCNT);
        done_d = (cnt_d == ACC_END) && (onij_d == ONIJ_LAST);
      end
`endif
      default: ;
    endcase
  end

  inst_pack u_pack (
    .acc      (f.acc),
    .cen_pmem (f.cen_pmem),
    .wen_pmem (f.wen_pmem),
    .a_pmem   (f.a_pmem),
    .cen_xmem (f.cen_xmem),
    .wen_xmem (f.wen_xmem),
    .a_xmem   (f.a_xmem),
    .ofifo_rd (f.ofifo_rd),
    .ififo_wr (f.ififo_wr),
    .ififo_rd (f.ififo_rd),
    .l0_rd    (f.l0_rd),
    .l0_wr    (f.l0_wr),
    .execute  (f.execute),
    .load     (f.load),
    .inst     (inst_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      onij_q  <= '0;
      inst_q  <= INST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      onij_q  <= onij_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_inst_seq.sv
// Randomized bench for inst_seq: per-cycle instruction trace compared with a
// phase-level model built from the run rules, plus aggregate event counts.
module tb_inst_seq;

  localparam int ROW = 8, COL = 8, NIJ = 36, ONIJ = 16, KIJ = 9;
  localparam int BUDGET = 6000;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        busy, done;

  int tests = 0;
  int fails = 0;

  logic [33:0] lg_inst[$];
  logic        lg_busy[$];
  logic        lg_done[$];
  logic        lg_v[$];
  logic [33:0] exp_q[$];
  bit          timed_out;

  int n_l0wr, n_load, n_exec, n_pw, n_rd, n_acc, n_both, n_wseq, n_done, n_busy_lo, n_rd_novalid;

  inst_seq dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic launch();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // mode 0: valid high, 1: toggling, 2: random. Logs one entry per cycle.
  task automatic capture(input int mode, input bit spam);
    bit stop_next = 0;
    bit seen = 0;
    int n = 0;
    lg_inst.delete(); lg_busy.delete(); lg_done.delete(); lg_v.delete();
    timed_out = 1'b1;
    while (n < BUDGET) begin
      case (mode)
        0: ofifo_valid = 1'b1;
        1: ofifo_valid = ~ofifo_valid;
        default: ofifo_valid = ($urandom_range(0, 2) != 0);
      endcase
      start = spam && !seen && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      lg_inst.push_back(inst); lg_busy.push_back(busy);
      lg_done.push_back(done); lg_v.push_back(ofifo_valid);
      n++;
      if (stop_next) begin timed_out = 1'b0; break; end
      if (done === 1'b1) begin stop_next = 1; seen = 1; end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  // Expected per-cycle instructions of a full run, from the phase rules.
  task automatic build_model();
    logic [33:0] w;
    int reads, waddr, c;
    bit pend;
    exp_q.delete();
    for (int k = 0; k < KIJ; k++) begin
      for (int t = 0; t <= COL; t++) begin
        w = IDLE_W;
        if (t < COL) begin w[19] = 1'b0; w[17:7] = 11'(1024 + t); end
        if (t >= 1) w[2] = 1'b1;
        exp_q.push_back(w);
      end
      repeat (ROW + 1) begin w = IDLE_W; w[0] = 1'b1; w[3] = 1'b1; exp_q.push_back(w); end
      repeat (10) exp_q.push_back(IDLE_W);
      for (int t = 0; t <= NIJ; t++) begin
        w = IDLE_W;
        if (t < NIJ) begin w[19] = 1'b0; w[17:7] = 11'(t); end
        if (t >= 1) w[2] = 1'b1;
        exp_q.push_back(w);
      end
      repeat (NIJ + 1) begin w = IDLE_W; w[1] = 1'b1; w[4] = 1'b1; exp_q.push_back(w); end
      reads = 0; pend = 0; waddr = 0;
      while (!(reads == ONIJ && !pend) && exp_q.size() < lg_v.size() + 4) begin
        c = exp_q.size();
        w = IDLE_W;
        if (pend) begin w[32] = 1'b0; w[31] = 1'b0; w[30:20] = 11'(waddr); end
        pend = 0;
        if (c >= 1 && c - 1 < lg_v.size() && reads < ONIJ) begin
          if (lg_v[c-1] === 1'b1) begin
            w[6] = 1'b1; waddr = k * ONIJ + reads; reads++; pend = 1;
          end
        end
        exp_q.push_back(w);
      end
      exp_q.push_back(IDLE_W);
    end
`ifdef ACC_PHASE_EN
    for (int o = 0; o < ONIJ; o++)
      for (int t = 0; t <= KIJ + 1; t++) begin
        w = IDLE_W;
        if (t < KIJ) begin w[32] = 1'b0; w[30:20] = 11'(t * ONIJ + o); end
        if (t >= 1 && t <= KIJ) w[33] = 1'b1;
        exp_q.push_back(w);
      end
`endif
  endtask

  task automatic tally();
    logic [33:0] w;
    n_l0wr = 0; n_load = 0; n_exec = 0; n_pw = 0; n_rd = 0; n_acc = 0;
    n_both = 0; n_wseq = 0; n_done = 0; n_busy_lo = 0; n_rd_novalid = 0;
    for (int i = 0; i < lg_inst.size(); i++) begin
      w = lg_inst[i];
      if (w[2]) n_l0wr++;
      if (w[0]) n_load++;
      if (w[1]) n_exec++;
      if (w[33]) n_acc++;
      if (w[6]) begin
        n_rd++;
        if (i == 0 || lg_v[i-1] !== 1'b1) n_rd_novalid++;
      end
      if (!w[32] && !w[31]) begin
        if (int'(w[30:20]) == n_pw) n_wseq++;
        n_pw++;
      end
      if (!w[32] && !w[19]) n_both++;
      if (lg_done[i]) n_done++;
      if (i < lg_inst.size() - 1 && lg_busy[i] !== 1'b1) n_busy_lo++;
    end
  endtask

  task automatic check_trace(input string name);
    int bad = 0, first = -1;
    logic [33:0] a = '0, e = '0;
    int sz = (exp_q.size() + 1 > lg_inst.size()) ? exp_q.size() + 1 : lg_inst.size();
    for (int i = 0; i < sz; i++) begin
      logic [33:0] ai, ei;
      ai = (i < lg_inst.size()) ? lg_inst[i] : 34'h0;
      ei = (i < exp_q.size()) ? exp_q[i] : IDLE_W;
      if (ai !== ei) begin
        bad++;
        if (first < 0) begin first = i; a = ai; e = ei; end
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s_trace: %0d bad cycles, first at %0d got %h want %h", name, bad, first, a, e);
    end
    tests++;
    if (timed_out || lg_done.size() != exp_q.size() + 1 || lg_done[exp_q.size()-1] !== 1'b1) begin
      fails++;
      $display("FAIL %s_done_pos: log %0d cycles timeout=%0d want done at %0d", name, lg_done.size(), timed_out, exp_q.size() - 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (inst !== IDLE_W) begin fails++; $display("FAIL reset_inst: got %h want %h", inst, IDLE_W); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (inst !== IDLE_W || busy !== 1'b0) begin
      fails++; $display("FAIL idle_hold: inst %h busy %b want %h 0", inst, busy, IDLE_W);
    end
  endtask

  task automatic test_full_run();
    launch(); capture(0, 0); build_model(); check_trace("full"); tally();
    tests++; if (n_l0wr != KIJ * (COL + NIJ)) begin fails++; $display("FAIL l0_wr_count: got %0d want %0d", n_l0wr, KIJ * (COL + NIJ)); end
    tests++; if (n_load != KIJ * (ROW + 1)) begin fails++; $display("FAIL load_count: got %0d want %0d", n_load, KIJ * (ROW + 1)); end
    tests++; if (n_exec != KIJ * (NIJ + 1)) begin fails++; $display("FAIL exec_count: got %0d want %0d", n_exec, KIJ * (NIJ + 1)); end
    tests++; if (n_pw != KIJ * ONIJ) begin fails++; $display("FAIL pmem_wr_count: got %0d want %0d", n_pw, KIJ * ONIJ); end
    tests++; if (n_wseq != KIJ * ONIJ) begin fails++; $display("FAIL pmem_addr_seq: got %0d in order want %0d", n_wseq, KIJ * ONIJ); end
    tests++; if (n_both != 0) begin fails++; $display("FAIL cen_overlap: got %0d want 0", n_both); end
    tests++; if (n_done != 1) begin fails++; $display("FAIL done_once: got %0d want 1", n_done); end
    tests++; if (n_busy_lo != 0) begin fails++; $display("FAIL busy_in_run: got %0d low cycles want 0", n_busy_lo); end
`ifdef ACC_PHASE_EN
    tests++; if (n_acc != KIJ * ONIJ) begin fails++; $display("FAIL acc_count: got %0d want %0d", n_acc, KIJ * ONIJ); end
`else
    tests++; if (n_acc != 0) begin fails++; $display("FAIL acc_count: got %0d want 0", n_acc); end
`endif
    tests++;
    if (lg_inst[lg_inst.size()-1] !== IDLE_W || lg_busy[lg_busy.size()-1] !== 1'b0) begin
      fails++; $display("FAIL post_idle: inst %h busy %b want %h 0", lg_inst[lg_inst.size()-1], lg_busy[lg_busy.size()-1], IDLE_W);
    end
  endtask

  task automatic test_drain_toggle();
    launch(); capture(1, 0); build_model(); check_trace("toggle"); tally();
    tests++; if (n_rd != KIJ * ONIJ) begin fails++; $display("FAIL toggle_rd_count: got %0d want %0d", n_rd, KIJ * ONIJ); end
    tests++; if (n_rd_novalid != 0) begin fails++; $display("FAIL toggle_rd_no_valid: got %0d want 0", n_rd_novalid); end
    tests++; if (n_wseq != KIJ * ONIJ) begin fails++; $display("FAIL toggle_addr_seq: got %0d want %0d", n_wseq, KIJ * ONIJ); end
  endtask

  task automatic test_random_valid();
    for (int r = 0; r < 2; r++) begin
      launch(); capture(2, 0); build_model(); check_trace("random"); tally();
      tests++; if (n_pw != KIJ * ONIJ) begin fails++; $display("FAIL random_pmem_wr: got %0d want %0d", n_pw, KIJ * ONIJ); end
    end
  endtask

  task automatic test_back_to_back();
    launch(); capture(2, 1); build_model(); check_trace("spam"); tally();
    tests++; if (n_done != 1) begin fails++; $display("FAIL spam_done_once: got %0d want 1", n_done); end
    launch(); capture(0, 0); build_model(); check_trace("b2b");
  endtask

  task automatic test_reset_mid_exec();
    launch();
    ofifo_valid = 1'b1;
    repeat (81) @(negedge clk);
    tests++; if (inst[1] !== 1'b1) begin fails++; $display("FAIL exec_before_reset: execute %b want 1", inst[1]); end
    #1 reset = 1'b0;
    #1;
    tests++; if (inst !== IDLE_W) begin fails++; $display("FAIL mid_reset_inst: got %h want %h", inst, IDLE_W); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    capture(0, 0); build_model(); check_trace("restart");
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_drain_toggle();
    test_random_valid();
    test_back_to_back();
    test_reset_mid_exec();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
